// File: rtl/button_gesture_decoder.sv
// Turns debounced press/release pulses into short-press, long-press and double-click events.
// Define BUTTON_GESTURE_REPEAT_EN to add auto-repeat pulses while a long press is held.
module button_gesture_decoder #(
  parameter int CNT_W         = 26,
  parameter int LONG_CYCLES   = 50000000,
  parameter int DCLICK_CYCLES = 15000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_down,
  input  logic btn_up,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic held
);

  localparam longint CNT_MAX = (64'(1) << CNT_W) - 1;

  // Terminal counts must be reachable without the counter wrapping.
  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CNT_MAX ||
      DCLICK_CYCLES < 2 || longint'(DCLICK_CYCLES) > CNT_MAX ||
      REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_params
    $error("button_gesture_decoder: cycle parameters out of range");
  end

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESSED     = 2'd1,
    WAIT_SECOND = 2'd2,
    HELD        = 2'd3
  } state_e;

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             short_nx, long_nx, dclick_nx;
  logic             dn, up;

  // A simultaneous press and release is meaningless and is dropped.
  assign dn = btn_down & ~btn_up;
  assign up = btn_up & ~btn_down;

`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
  logic long_held, long_held_nx;
  logic rpt_nx;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNT_W'(1);
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    dclick_nx = 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
    rpt_nx       = 1'b0;
    long_held_nx = long_held;
`endif
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (dn) state_nx = PRESSED;
      end
      PRESSED: begin
        if (up) begin
          state_nx = WAIT_SECOND;
        end else if (cnt == LONG_TC) begin
          state_nx = HELD;
          long_nx  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (dn) begin
          state_nx  = HELD;
          dclick_nx = 1'b1;
        end else if (cnt == DCLICK_TC) begin
          state_nx = IDLE;
          short_nx = 1'b1;
        end
      end
      HELD: begin
        cnt_nx = '0;
        if (up) begin
          state_nx = IDLE;
`ifdef BUTTON_GESTURE_REPEAT_EN
        end else if (long_held) begin
          // The counter rests during the long_press cycle, so the first repeat lands REPEAT_CYCLES+1 after it.
          if (long_press) begin
            cnt_nx = '0;
          end else if (cnt == REPEAT_TC) begin
            rpt_nx = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state_nx != state) cnt_nx = '0;

`ifdef BUTTON_GESTURE_REPEAT_EN
    if (state_nx != HELD) long_held_nx = 1'b0;
    else if (state == PRESSED) long_held_nx = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      short_press  <= short_nx;
      long_press   <= long_nx;
      double_click <= dclick_nx;
      held         <= (state_nx == PRESSED) || (state_nx == HELD);
    end
  end

`ifdef BUTTON_GESTURE_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_held    <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      long_held    <= long_held_nx;
      repeat_pulse <= rpt_nx;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with short timing parameters.
// Outputs are sampled and inputs changed on the falling edge; cycle 0 is the first btn_down.
module tb_button_gesture_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_down, btn_up;
  logic short_press, long_press, double_click, repeat_pulse, held;

  int vectors     = 0;
  int miscompares = 0;

  button_gesture_decoder #(
    .CNT_W        (8),
    .LONG_CYCLES  (8),
    .DCLICK_CYCLES(5),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_down    (btn_down),
    .btn_up      (btn_up),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  // Bit order: {short_press, long_press, double_click, repeat_pulse, held}
  function automatic logic [4:0] outs();
    return {short_press, long_press, double_click, repeat_pulse, held};
  endfunction

  task automatic test_reset;
    logic [4:0] exp;
    rst_n    = 1'b0;
    btn_down = 1'($urandom_range(1, 0));
    btn_up   = 1'($urandom_range(1, 0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (outs() !== 5'b0) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %b, expected %b", i, outs(), 5'b0);
      end
      btn_down = 1'($urandom_range(1, 0));
      btn_up   = 1'($urandom_range(1, 0));
    end
    rst_n    = 1'b1;
    btn_down = 1'b0;
    btn_up   = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      exp = 5'b0;
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL stray_release cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_up = (c == 3);
    end
    btn_up = 1'b0;
  endtask

  task automatic test_short_press;
    logic [4:0] exp;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      exp = {c == 9, 1'b0, 1'b0, 1'b0, c >= 1 && c <= 3};
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL short_press cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_down = (c == 0);
      btn_up   = (c == 3);
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_long_press;
    logic [4:0] exp;
    logic       exp_rpt;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
`ifdef BUTTON_GESTURE_REPEAT_EN
      exp_rpt = (c == 13) || (c == 16) || (c == 19);
`else
      exp_rpt = 1'b0;
`endif
      exp = {1'b0, c == 9, 1'b0, exp_rpt, c >= 1 && c <= 20};
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL long_press cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_down = (c == 0);
      btn_up   = (c == 20);
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_long_boundary;
    logic [4:0] exp;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      exp = {c == 14, 1'b0, 1'b0, 1'b0, c >= 1 && c <= 8};
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL long_boundary cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_down = (c == 0);
      btn_up   = (c == 8);
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_double_click;
    logic [4:0] exp;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, c == 6, 1'b0, (c >= 1 && c <= 2) || (c >= 6 && c <= 10)};
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL double_click cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_down = (c == 0) || (c == 5);
      btn_up   = (c == 2) || (c == 10);
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
  endtask

  // Both pulses at once are dropped; a press during PRESSED is ignored.
  task automatic test_illegal_inputs;
    logic [4:0] exp;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      exp = {c == 10, 1'b0, 1'b0, 1'b0, c >= 3 && c <= 4};
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL illegal_inputs cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_down = (c == 0) || (c == 2) || (c == 3);
      btn_up   = (c == 0) || (c == 4);
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_reset_mid_gesture;
    logic [4:0] exp;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, 1'b0, 1'b0, c >= 1 && c <= 4};
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_gesture cycle %0d: got %b, expected %b", c, outs(), exp);
      end
      btn_down = (c == 0);
      btn_up   = (c == 6);
      rst_n    = (c != 4);
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_long_boundary();
    test_double_click();
    test_illegal_inputs();
    test_reset_mid_gesture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
